// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle byte ALU.
//   DATA_W      operand / result width (fixed at 8)
//   STATE_N     number of controller states (one-hot width)
//   ST_*        bit index of each state inside the one-hot vector
//   OP_*        operation encodings carried on op_code
//   state_t     one-hot controller state type
package alu_pkg;

  localparam int DATA_W  = 8;
  localparam int STATE_N = 17;

  localparam int ST_IDLE     = 0;
  localparam int ST_LOAD_M   = 1;
  localparam int ST_ADD      = 2;
  localparam int ST_SUB      = 3;
  localparam int ST_MUL_CHK  = 4;
  localparam int ST_MUL_ADD  = 5;
  localparam int ST_MUL_SHR  = 6;
  localparam int ST_MUL_LOOP = 7;
  localparam int ST_DIV_CHK  = 8;
  localparam int ST_DIV_SHL  = 9;
  localparam int ST_DIV_SUB  = 10;
  localparam int ST_DIV_SETQ = 11;
  localparam int ST_DIV_LOOP = 12;
  localparam int ST_OUT_LO   = 13;
  localparam int ST_OUT_HI   = 14;
  localparam int ST_OUT_RES  = 15;
  localparam int ST_DIV_ZERO = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [STATE_N-1:0] {
    S_IDLE     = 17'd1 << ST_IDLE,
    S_LOAD_M   = 17'd1 << ST_LOAD_M,
    S_ADD      = 17'd1 << ST_ADD,
    S_SUB      = 17'd1 << ST_SUB,
    S_MUL_CHK  = 17'd1 << ST_MUL_CHK,
    S_MUL_ADD  = 17'd1 << ST_MUL_ADD,
    S_MUL_SHR  = 17'd1 << ST_MUL_SHR,
    S_MUL_LOOP = 17'd1 << ST_MUL_LOOP,
    S_DIV_CHK  = 17'd1 << ST_DIV_CHK,
    S_DIV_SHL  = 17'd1 << ST_DIV_SHL,
    S_DIV_SUB  = 17'd1 << ST_DIV_SUB,
    S_DIV_SETQ = 17'd1 << ST_DIV_SETQ,
    S_DIV_LOOP = 17'd1 << ST_DIV_LOOP,
    S_OUT_LO   = 17'd1 << ST_OUT_LO,
    S_OUT_HI   = 17'd1 << ST_OUT_HI,
    S_OUT_RES  = 17'd1 << ST_OUT_RES,
    S_DIV_ZERO = 17'd1 << ST_DIV_ZERO
  } state_t;

endpackage

// File: rtl/alu_adder9.sv
// alu_adder9: 9-bit ripple-carry add/subtract unit shared by every
// arithmetic step of the ALU.
//   a, b  in  9   operands
//   sub   in  1   0: sum = a + b, 1: sum = a - b (two's complement)
//   sum   out 9   result, modulo 512
module alu_adder9
  import alu_pkg::*;
(
  input  logic [DATA_W:0] a,
  input  logic [DATA_W:0] b,
  input  logic            sub,
  output logic [DATA_W:0] sum
);

  logic [DATA_W:0] b_eff;

  // Subtraction is a + ~b + 1: invert b and feed sub in as the carry-in.
  assign b_eff = b ^ {(DATA_W+1){sub}};

  always_comb begin : ripple
    logic c;
    c   = sub;
    sum = '0;
    for (int i = 0; i <= DATA_W; i++) begin
      sum[i] = a[i] ^ b_eff[i] ^ c;
      c      = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
    end
  end

endmodule

// File: rtl/alu_core.sv
// alu_core: multi-cycle 8-bit integer ALU (add, sub, shift-add multiply,
// restoring divide) fed serially from a byte bus.
//   clk               in  1   clock, rising edge
//   reset             in  1   synchronous, active-high
//   BEGIN             in  1   start strobe, sampled in IDLE only
//   op_code           in  2   00 add, 01 sub, 10 mul, 11 div
//   inbus             in  8   operand 1 (IDLE edge), operand 2 (LOAD_M edge)
//   outbus            out 8   result byte, 0 outside output states
//   END               out 1   high while outbus carries a result byte
//   act_state_debug   out 17  current one-hot state
//   next_state_debug  out 17  combinational next state
//   A/Q/M_reg_debug   out 8   A[7:0], Q, M
// Multiply/divide return two bytes: Q first (product low / quotient),
// then A (product high / remainder).
module alu_core
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                BEGIN,
  input  logic [1:0]          op_code,
  input  logic [DATA_W-1:0]   inbus,
  output logic [DATA_W-1:0]   outbus,
  output logic                END,
  output logic [STATE_N-1:0]  act_state_debug,
  output logic [STATE_N-1:0]  next_state_debug,
  output logic [DATA_W-1:0]   A_reg_debug,
  output logic [DATA_W-1:0]   Q_reg_debug,
  output logic [DATA_W-1:0]   M_reg_debug
);

  state_t            state;
  state_t            next;
  logic [DATA_W:0]   a_reg;
  logic [DATA_W-1:0] q_reg;
  logic [DATA_W-1:0] m_reg;
  logic [2:0]        cnt;
  logic [1:0]        op_reg;

  logic [DATA_W:0]   add_a;
  logic [DATA_W:0]   add_b;
  logic              add_sub;
  logic [DATA_W:0]   add_sum;

  // Shared adder operand selection
  always_comb begin
    add_a   = a_reg;
    add_b   = {1'b0, m_reg};
    add_sub = 1'b0;
    case (state)
      S_ADD:     add_a = {1'b0, q_reg};
      S_SUB: begin
        add_a   = {1'b0, q_reg};
        add_sub = 1'b1;
      end
      // Multiply accumulates on A[7:0]; the carry lands in A[8].
      S_MUL_ADD: add_a = {1'b0, a_reg[DATA_W-1:0]};
      S_DIV_SUB: add_sub = 1'b1;
      default: ;
    endcase
  end

  alu_adder9 u_adder (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_sum)
  );

  // Controller: state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  // Controller: next-state decode
  always_comb begin
    next = state;
    case (state)
      S_IDLE:     if (BEGIN) next = S_LOAD_M;
      S_LOAD_M: begin
        case (op_reg)
          OP_ADD:  next = S_ADD;
          OP_SUB:  next = S_SUB;
          OP_MUL:  next = S_MUL_CHK;
          OP_DIV:  next = S_DIV_CHK;
          default: next = S_IDLE;
        endcase
      end
      S_ADD:      next = S_OUT_RES;
      S_SUB:      next = S_OUT_RES;
      S_MUL_CHK:  next = q_reg[0] ? S_MUL_ADD : S_MUL_SHR;
      S_MUL_ADD:  next = S_MUL_SHR;
      S_MUL_SHR:  next = S_MUL_LOOP;
      // cnt wraps to 0 after the eighth increment.
      S_MUL_LOOP: next = (cnt == 3'd0) ? S_OUT_LO : S_MUL_CHK;
      S_DIV_CHK:  next = (m_reg == '0) ? S_DIV_ZERO : S_DIV_SHL;
      S_DIV_SHL:  next = S_DIV_SUB;
      S_DIV_SUB:  next = S_DIV_SETQ;
      S_DIV_SETQ: next = S_DIV_LOOP;
      S_DIV_LOOP: next = (cnt == 3'd0) ? S_OUT_LO : S_DIV_SHL;
      S_DIV_ZERO: next = S_OUT_LO;
      S_OUT_LO:   next = S_OUT_HI;
      S_OUT_HI:   next = S_IDLE;
      S_OUT_RES:  next = S_IDLE;
      default:    next = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      q_reg  <= '0;
      m_reg  <= '0;
      cnt    <= '0;
      op_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (BEGIN) begin
            q_reg  <= inbus;
            op_reg <= op_code;
            a_reg  <= '0;
            cnt    <= '0;
          end
        end
        S_LOAD_M:  m_reg <= inbus;
        S_ADD, S_SUB, S_MUL_ADD, S_DIV_SUB: a_reg <= add_sum;
        S_MUL_SHR: begin
          {a_reg, q_reg} <= {1'b0, a_reg, q_reg[DATA_W-1:1]};
          cnt            <= cnt + 3'd1;
        end
        // A[8] is always 0 here (partial remainder < M), so dropping it is safe.
        S_DIV_SHL: {a_reg, q_reg} <= {a_reg[DATA_W-1:0], q_reg, 1'b0};
        S_DIV_SETQ: begin
          if (a_reg[DATA_W]) begin
            a_reg    <= add_sum;
            q_reg[0] <= 1'b0;
          end else begin
            q_reg[0] <= 1'b1;
          end
          cnt <= cnt + 3'd1;
        end
        S_DIV_ZERO: begin
          a_reg <= {1'b0, q_reg};
          q_reg <= '1;
        end
        default: ;
      endcase
    end
  end

  // Output decode from current state
  always_comb begin
    outbus = '0;
    END    = 1'b0;
    case (state)
      S_OUT_RES: begin
        outbus = a_reg[DATA_W-1:0];
        END    = 1'b1;
      end
      S_OUT_LO: begin
        outbus = q_reg;
        END    = 1'b1;
      end
      S_OUT_HI: begin
        outbus = a_reg[DATA_W-1:0];
        END    = 1'b1;
      end
      default: ;
    endcase
  end

  assign act_state_debug  = state;
  assign next_state_debug = next;
  assign A_reg_debug      = a_reg[DATA_W-1:0];
  assign Q_reg_debug      = q_reg;
  assign M_reg_debug      = m_reg;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed-vector bench for alu_core.
module tb_alu_core;

  logic        clk;
  logic        reset;
  logic        BEGIN;
  logic [1:0]  op_code;
  logic [7:0]  inbus;
  logic [7:0]  outbus;
  logic        END;
  logic [16:0] act_state_debug;
  logic [16:0] next_state_debug;
  logic [7:0]  A_reg_debug;
  logic [7:0]  Q_reg_debug;
  logic [7:0]  M_reg_debug;

  int total = 0;
  int bad   = 0;

  alu_core dut (
    .clk              (clk),
    .reset            (reset),
    .BEGIN            (BEGIN),
    .op_code          (op_code),
    .inbus            (inbus),
    .outbus           (outbus),
    .END              (END),
    .act_state_debug  (act_state_debug),
    .next_state_debug (next_state_debug),
    .A_reg_debug      (A_reg_debug),
    .Q_reg_debug      (Q_reg_debug),
    .M_reg_debug      (M_reg_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents operand 1 with BEGIN for one edge, then operand 2; returns
  // just before the edge that captures operand 2.
  task automatic start_op(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    BEGIN = 1'b1; op_code = op; inbus = x;
    @(negedge clk);
    BEGIN = 1'b0; inbus = y;
  endtask

  // Counts negedges until END is seen; cyc = -1 if the budget runs out.
  task automatic wait_end(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      inbus = 8'h00;
    end while (END !== 1'b1 && cyc < limit);
    if (END !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; BEGIN = 1'b1; op_code = 2'b10; inbus = 8'hAA;
    repeat (3) @(negedge clk);
    total++; if (act_state_debug !== 17'h00001) begin bad++; $display("FAIL reset_state got=%0h want=1", act_state_debug); end
    total++; if (outbus !== 8'h00 || END !== 1'b0) begin bad++; $display("FAIL reset_out got=%0h/%0b want=0/0", outbus, END); end
    total++; if (Q_reg_debug !== 8'h00 || A_reg_debug !== 8'h00 || M_reg_debug !== 8'h00) begin
      bad++; $display("FAIL reset_regs got=%0h/%0h/%0h want=0/0/0", A_reg_debug, Q_reg_debug, M_reg_debug);
    end
    BEGIN = 1'b0; reset = 1'b0; inbus = 8'h00;
    @(negedge clk);
    total++; if (act_state_debug !== 17'h00001) begin bad++; $display("FAIL idle_hold got=%0h want=1", act_state_debug); end
  endtask

  task automatic test_addsub();
    int cyc;
    start_op(2'b00, 8'd3, 8'd2);
    wait_end(10, cyc);
    total++; if (cyc !== 2) begin bad++; $display("FAIL add_latency got=%0d want=2", cyc); end
    total++; if (outbus !== 8'd5) begin bad++; $display("FAIL add_3_2 got=%0d want=5", outbus); end
    @(negedge clk);
    total++; if (END !== 1'b0 || outbus !== 8'h00) begin bad++; $display("FAIL add_end_width got=%0b/%0h want=0/0", END, outbus); end

    start_op(2'b01, 8'd2, 8'd3);
    wait_end(10, cyc);
    total++; if (cyc !== 2 || outbus !== 8'hFF) begin bad++; $display("FAIL sub_2_3 got=%0h cyc=%0d want=ff cyc=2", outbus, cyc); end
    @(negedge clk);

    start_op(2'b00, 8'd200, 8'd100);
    wait_end(10, cyc);
    total++; if (outbus !== 8'd44) begin bad++; $display("FAIL add_wrap got=%0d want=44", outbus); end
    @(negedge clk);
  endtask

  task automatic test_mul();
    int cyc;
    start_op(2'b10, 8'd7, 8'd3);
    wait_end(60, cyc);
    total++; if (cyc !== 28) begin bad++; $display("FAIL mul7x3_latency got=%0d want=28", cyc); end
    total++; if (outbus !== 8'd21) begin bad++; $display("FAIL mul7x3_lo got=%0h want=15", outbus); end
    total++; if ($countones(act_state_debug) !== 1) begin bad++; $display("FAIL onehot got=%0h want=one bit", act_state_debug); end
    @(negedge clk);
    total++; if (END !== 1'b1 || outbus !== 8'd0) begin bad++; $display("FAIL mul7x3_hi got=%0h/%0b want=0/1", outbus, END); end
    @(negedge clk);
    total++; if (END !== 1'b0) begin bad++; $display("FAIL mul_end_drop got=%0b want=0", END); end

    start_op(2'b10, 8'd255, 8'd255);
    wait_end(60, cyc);
    total++; if (cyc !== 33) begin bad++; $display("FAIL mulffxff_latency got=%0d want=33", cyc); end
    total++; if (outbus !== 8'h01) begin bad++; $display("FAIL mulffxff_lo got=%0h want=01", outbus); end
    @(negedge clk);
    total++; if (outbus !== 8'hFE) begin bad++; $display("FAIL mulffxff_hi got=%0h want=fe", outbus); end
    @(negedge clk);
  endtask

  task automatic test_div();
    int cyc;
    start_op(2'b11, 8'd23, 8'd5);
    wait_end(60, cyc);
    total++; if (cyc !== 34) begin bad++; $display("FAIL div_latency got=%0d want=34", cyc); end
    total++; if (outbus !== 8'd4) begin bad++; $display("FAIL div23_5_quot got=%0d want=4", outbus); end
    @(negedge clk);
    total++; if (END !== 1'b1 || outbus !== 8'd3) begin bad++; $display("FAIL div23_5_rem got=%0d/%0b want=3/1", outbus, END); end
    @(negedge clk);

    start_op(2'b11, 8'd9, 8'd0);
    wait_end(20, cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL div0_latency got=%0d want=3", cyc); end
    total++; if (outbus !== 8'hFF) begin bad++; $display("FAIL div0_quot got=%0h want=ff", outbus); end
    @(negedge clk);
    total++; if (outbus !== 8'd9) begin bad++; $display("FAIL div0_rem got=%0h want=09", outbus); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    BEGIN = 1'b1; op_code = 2'b00; inbus = 8'd1;
    @(negedge clk);
    inbus = 8'd1;
    @(negedge clk);
    inbus = 8'd9;
    @(negedge clk);
    total++; if (END !== 1'b1 || outbus !== 8'd2) begin bad++; $display("FAIL b2b_first got=%0d/%0b want=2/1", outbus, END); end
    @(negedge clk);
    total++; if (act_state_debug !== 17'h00001) begin bad++; $display("FAIL b2b_idle got=%0h want=1", act_state_debug); end
    @(negedge clk);
    total++; if (act_state_debug !== 17'h00002 || Q_reg_debug !== 8'd9) begin
      bad++; $display("FAIL b2b_restart got=%0h/%0d want=2/9", act_state_debug, Q_reg_debug);
    end
    BEGIN = 1'b0; inbus = 8'd6;
    @(negedge clk);
    inbus = 8'd0;
    @(negedge clk);
    total++; if (END !== 1'b1 || outbus !== 8'd15) begin bad++; $display("FAIL b2b_second got=%0d/%0b want=15/1", outbus, END); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int seen_end;
    seen_end = 0;
    start_op(2'b10, 8'd255, 8'd255);
    repeat (12) begin
      @(negedge clk);
      inbus = 8'h00;
      if (END === 1'b1) seen_end++;
    end
    reset = 1'b1;
    @(negedge clk);
    if (END === 1'b1) seen_end++;
    total++; if (act_state_debug !== 17'h00001) begin bad++; $display("FAIL midreset_state got=%0h want=1", act_state_debug); end
    total++; if (A_reg_debug !== 8'h00 || Q_reg_debug !== 8'h00 || M_reg_debug !== 8'h00) begin
      bad++; $display("FAIL midreset_regs got=%0h/%0h/%0h want=0/0/0", A_reg_debug, Q_reg_debug, M_reg_debug);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (END === 1'b1) seen_end++;
    end
    total++; if (seen_end !== 0) begin bad++; $display("FAIL midreset_end got=%0d want=0", seen_end); end
  endtask

  initial begin
    reset = 1'b0; BEGIN = 1'b0; op_code = 2'b00; inbus = 8'h00;
    test_reset();
    test_addsub();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
